pt_dec: RTL and testbench

PT2272-style decoder: the receive-side counterpart of the `cb_gen` PT2262 code-word generator. It oversamples a single OOK/ASK data line, measures pulse widths, rebuilds the 12 tri-state code bits (trits) plus the sync gap, and presents each accepted code word with a one-cycle valid strobe. It sits between the RF receiver input pin and the UART reporting logic on the UPduino top level, clocked from the divided LFOSC clock.

---
 rtl/pt_pkg.sv | 41 ++++
 rtl/pt_pulse_meas.sv | 66 ++++++
 rtl/pt_dec.sv | 131 +++++++++++++
 tb/tb_pt_dec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared PT2262/PT2272 code-word definitions (used by pt_dec and cb_gen).
package pt_pkg;

  localparam int TRITS_PER_WORD  = 12;
  localparam int PULSES_PER_WORD = 24;
  localparam int CODE_W          = 2 * TRITS_PER_WORD;

  localparam logic [1:0] TRIT_ZERO  = 2'b00;
  localparam logic [1:0] TRIT_ONE   = 2'b01;
  localparam logic [1:0] TRIT_FLOAT = 2'b10;

  typedef enum logic [1:0] {
    PULSE_SHORT = 2'd0,
    PULSE_LONG  = 2'd1,
    PULSE_BAD   = 2'd2
  } pulse_t;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ARMED,
    ST_HIGH,
    ST_LOW
  } dec_state_t;

  typedef struct packed {
    logic   rise;
    logic   fall;
    logic   low_bad;
    pulse_t kind;
    logic   hi_long;
    logic   gap;
  } meas_t;

  // long,short is rejected before this is called
  function automatic logic [1:0] trit_of(pulse_t a, pulse_t b);
    if (a == PULSE_LONG)      return TRIT_ONE;
    else if (b == PULSE_LONG) return TRIT_FLOAT;
    else                      return TRIT_ZERO;
  endfunction

endpackage

// File: rtl/pt_pulse_meas.sv
// rx synchronizer, edge detect, saturating width counter and
// short/long/gap classifier; all outputs are registered strobes.
module pt_pulse_meas
  import pt_pkg::*;
#(
  parameter int UNIT       = 8,
  parameter int SYNC_UNITS = 16
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  rx,
  output meas_t meas
);

  localparam int MAXW = SYNC_UNITS * UNIT;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] C_HALF = CW'(UNIT / 2);
  localparam logic [CW-1:0] C_2U   = CW'(2 * UNIT);
  localparam logic [CW-1:0] C_4U   = CW'(4 * UNIT);
  localparam logic [CW-1:0] C_MAX  = CW'(MAXW);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic          s1;
  logic          rs;
  logic          rs_d;
  logic [CW-1:0] cnt;
  logic          edge_c;
  pulse_t        kind_c;

  assign edge_c = rs ^ rs_d;

  always_comb begin
    kind_c = PULSE_BAD;
    if (cnt >= C_HALF && cnt < C_2U)
      kind_c = PULSE_SHORT;
    else if (cnt >= C_2U && cnt < C_4U)
      kind_c = PULSE_LONG;
  end

  // cnt equals the width of the level just ended when an edge is seen
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      rs   <= 1'b0;
      rs_d <= 1'b0;
      cnt  <= '0;
      meas <= '0;
    end else begin
      s1   <= rx;
      rs   <= s1;
      rs_d <= rs;
      if (edge_c)
        cnt <= C_ONE;
      else if (cnt != C_MAX)
        cnt <= cnt + C_ONE;
      meas.rise    <= rs & ~rs_d;
      meas.fall    <= ~rs & rs_d;
      meas.kind    <= kind_c;
      meas.low_bad <= (cnt >= C_4U) && (cnt < C_MAX);
      meas.hi_long <= rs & rs_d & (cnt == C_4U - C_ONE);
      meas.gap     <= ~rs & ~rs_d & (cnt == C_MAX - C_ONE);
    end
  end

endmodule

// File: rtl/pt_dec.sv
// PT2272-style tri-state code-word decoder.
// Define PT_DEC_REPEAT_CHECK_EN to require two identical words in a row.
module pt_dec
  import pt_pkg::*;
#(
  parameter int UNIT       = 8,
  parameter int SYNC_UNITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              err
);

  localparam logic [4:0] LAST = 5'(PULSES_PER_WORD - 1);

  meas_t             m;
  dec_state_t        state;
  logic [4:0]        idx;
  logic [CODE_W-1:0] sh;
  pulse_t            first;
  logic              pair_bad;
  logic              hi_fail;
  logic              lo_fail;
  logic              fail;
  logic              done;
  logic              accept;

  pt_pulse_meas #(
    .UNIT       (UNIT),
    .SYNC_UNITS (SYNC_UNITS)
  ) u_meas (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .meas    (m)
  );

  assign pair_bad = idx[0] && first == PULSE_LONG
                    && m.kind == PULSE_SHORT;

  assign hi_fail = state == ST_HIGH
                   && (m.hi_long
                       || (m.fall && (m.kind == PULSE_BAD
                                      || pair_bad)));

  assign lo_fail = state == ST_LOW
                   && ((m.rise && (idx == LAST || m.low_bad))
                       || (m.gap && idx != LAST));

  assign fail = hi_fail || lo_fail;
  assign done = state == ST_LOW && m.gap && idx == LAST;

`ifdef PT_DEC_REPEAT_CHECK_EN
  logic [CODE_W-1:0] prev;
  logic              prev_ok;

  always_ff @(posedge clk) begin
    if (!reset_n || fail) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (done) begin
      prev    <= sh;
      prev_ok <= 1'b1;
    end
  end

  assign accept = done && prev_ok && prev == sh;
`else
  assign accept = done;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_HUNT;
      idx   <= '0;
      sh    <= '0;
      first <= PULSE_SHORT;
      code  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= accept;
      err   <= fail;
      if (accept)
        code <= sh;
      unique case (state)
        ST_HUNT:
          if (m.gap)
            state <= ST_ARMED;
        ST_ARMED:
          if (m.rise) begin
            state <= ST_HIGH;
            idx   <= '0;
            sh    <= '0;
          end
        ST_HIGH:
          if (hi_fail) begin
            state <= ST_HUNT;
            sh    <= '0;
          end else if (m.fall) begin
            state <= ST_LOW;
            if (!idx[0])
              first <= m.kind;
            else
              sh <= {sh[CODE_W-3:0], trit_of(first, m.kind)};
          end
        ST_LOW:
          if (m.rise) begin
            if (lo_fail) begin
              state <= ST_HUNT;
              sh    <= '0;
            end else begin
              state <= ST_HIGH;
              idx   <= idx + 5'd1;
            end
          end else if (m.gap) begin
            // a gap always re-arms; a short word is also an error
            state <= ST_ARMED;
            if (lo_fail)
              sh <= '0;
          end
        default:
          state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_pt_dec.sv
// Bench for pt_dec: word table plus reset and spacing sequences.
// Expected strobes come from a scoreboard queue filled at send time.
module tb_pt_dec;

  localparam int U  = 4;
  localparam int SU = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b0;
  logic [23:0] code;
  logic        valid;
  logic        err;

  pt_dec #(.UNIT(U), .SYNC_UNITS(SU)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .code    (code),
    .valid   (valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          val_cnt = 0;
  longint      cyc = 0;
  longint      vcyc[$];
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  longint      gap_start;

  // bench model of the accepted-word state
  logic [23:0] exp_code = '0;
  logic [23:0] m_prev = '0;
  bit          m_ok = 1'b0;

  typedef struct {
    logic [23:0] w;
    int          fault;
    int          n_err;
  } vec_t;

  vec_t tbl[11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (err)
        err_cnt++;
      if (valid) begin
        val_cnt++;
        vcyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL valid_unexpected: code=%h required no valid",
                   code);
        end else begin
          mon_e = exp_q.pop_front();
          if (code !== mon_e) begin
            n_bad++;
            $display("FAIL valid_code: got %h required %h", code, mon_e);
          end
        end
      end
    end
  end

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  // fault 1: pulse 7 held high 5 units; fault 3: only 20 pulses
  task automatic send_word(logic [23:0] w, int fault, int rst_at);
    int np;
    int k;
    int h;
    int l;
    logic [1:0] t;
    bit lng;
    np = (fault == 3) ? 20 : 24;
    for (int p = 0; p < np; p++) begin
      k = 11 - p / 2;
      t = w[2*k +: 2];
      if (p % 2 == 0)
        lng = (t == 2'b01) || (t == 2'b11);
      else
        lng = (t == 2'b01) || (t == 2'b10);
      h = lng ? 3 * U : U;
      l = lng ? U : 3 * U;
      if (fault == 1 && p == 7)
        h = 5 * U;
      if (p == rst_at) begin
        reset_n = 1'b0;
        hold(1);
        check("rst_code", code, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        m_ok = 1'b0;
        exp_code = '0;
      end
      rx = 1'b1;
      hold(h);
      rx = 1'b0;
      if (p == np - 1) begin
        gap_start = cyc;
        l = 31 * U;
      end
      hold(l);
    end
  endtask

  task automatic run_word(logic [23:0] w, int fault, int n_err,
                          string name);
    int  e0;
    int  v0;
    bit  will;
    e0 = err_cnt;
    v0 = val_cnt;
    will = 1'b0;
    if (fault == 0) begin
`ifdef PT_DEC_REPEAT_CHECK_EN
      will = m_ok && (m_prev == w);
`else
      will = 1'b1;
`endif
      m_prev = w;
      m_ok = 1'b1;
    end else begin
      m_ok = 1'b0;
    end
    if (will)
      exp_q.push_back(w);
    send_word(w, fault, -1);
    if (will)
      exp_code = w;
    check({name, "_err"}, err_cnt - e0, n_err);
    check({name, "_nvalid"}, val_cnt - v0, will ? 1 : 0);
    check({name, "_code"}, code, exp_code);
  endtask

  initial begin
    int e0;
    int v0;
    longint g2;
    longint g3;
    tbl[0]  = '{24'h000000, 0, 0};
    tbl[1]  = '{24'h000000, 0, 0};
    tbl[2]  = '{24'h640000, 0, 0};
    tbl[3]  = '{24'h640000, 0, 0};
    tbl[4]  = '{24'h640000, 1, 1};
    tbl[5]  = '{24'h640000, 0, 0};
    tbl[6]  = '{24'h640000, 0, 0};
    tbl[7]  = '{24'h6400C0, 2, 1};
    tbl[8]  = '{24'h640000, 3, 1};
    tbl[9]  = '{24'h2A1560, 0, 0};
    tbl[10] = '{24'h2A1560, 0, 0};

    reset_n = 1'b0;
    rx = 1'b0;
    hold(3);
    check("reset_code", code, 0);
    check("reset_valid", valid, 0);
    check("reset_err", err, 0);
    reset_n = 1'b1;

    // idle low line: hunt finds the gap and then sits armed silently
    e0 = err_cnt;
    v0 = val_cnt;
    hold(300);
    check("idle_err", err_cnt - e0, 0);
    check("idle_valid", val_cnt - v0, 0);

    for (int i = 0; i < 11; i++)
      run_word(tbl[i].w, tbl[i].fault, tbl[i].n_err,
               $sformatf("vec%0d", i));

    // reset in the middle of a word; the rest must be ignored
    e0 = err_cnt;
    v0 = val_cnt;
    send_word(24'h261849, 0, 10);
    check("rstmid_err", err_cnt - e0, 0);
    check("rstmid_valid", val_cnt - v0, 0);
    check("rstmid_code", code, 0);

    run_word(24'h261849, 0, 0, "post_rst1");
    run_word(24'h261849, 0, 0, "post_rst2");
    g2 = gap_start;
    run_word(24'h261849, 0, 0, "post_rst3");
    g3 = gap_start;

    // back-to-back words: strobe spacing equals the word period
    check("spacing_n", (vcyc.size() >= 2) ? 1 : 0, 1);
    if (vcyc.size() >= 2)
      check("spacing", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2],
            g3 - g2);

    hold(20);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
